// File: rtl/regfile_param.sv
// regfile_param: DEPTH x WIDTH register file, byte-strobed write port, two combinational read ports with optional write-through bypass
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WIDTH-1:0]     rdata_b
);
  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] old, merged;
  logic wok;
  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEP) && !(ZERO_REG != 0 && a == '0);
  endfunction
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    return legal(a) ? ((BYPASS != 0 && wok && a == waddr) ? merged : mem[a]) : '0;
  endfunction
  always_comb begin
    old = legal(waddr) ? mem[waddr] : '0;
    merged = old;
    for (int k = 0; k < NB; k++)
      merged[8*k +: 8] = wstrb[k] ? wdata[8*k +: 8] : old[8*k +: 8];
    wok = we && !reset && legal(waddr);
  end
  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk)
      if (reset) mem[g] <= '0;
      else if (wok && waddr == ADDR_W'(g)) mem[g] <= merged;
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and model-based random checks of two regfile_param configurations driven in parallel
module tb_regfile_param;
  logic clk = 0, reset = 0, we = 0;
  logic [4:0] waddr = 0, ra = 0, rb = 0;
  logic [3:0] wstrb = 0;
  logic [31:0] wdata = 0;
  logic [31:0] a0, b0, a1, b1;
  int checks = 0, errors = 0;
  logic [31:0] mm [2][32];
  always #5 clk = ~clk;
  regfile_param u0 (.clk(clk), .reset(reset), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .raddr_a(ra), .rdata_a(a0), .raddr_b(rb), .rdata_b(b0));
  regfile_param #(.DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .reset(reset), .we(we), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .raddr_a(ra), .rdata_a(a1), .raddr_b(rb), .rdata_b(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic writable(input int c, input logic [4:0] a);
    return (c == 1 ? a < 24 : 1'b1) && !(c == 0 && a == 0);
  endfunction
  function automatic logic [31:0] mrg(input logic [31:0] v);
    logic [31:0] r = v;
    for (int k = 0; k < 4; k++) if (wstrb[k]) r[8*k +: 8] = wdata[8*k +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mrd(input int c, input logic [4:0] a);
    if (!writable(c, a)) return 32'h0;
    if (c == 0 && we && !reset && a == waddr) return mrg(mm[c][a]);
    return mm[c][a];
  endfunction
  task automatic set(input logic w, input logic [4:0] wa, input logic [3:0] ws, input logic [31:0] wd,
                     input logic [4:0] ra_, input logic [4:0] rb_);
    we = w; waddr = wa; wstrb = ws; wdata = wd; ra = ra_; rb = rb_;
    #3;
  endtask
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 2; c++)
      if (reset) for (int i = 0; i < 32; i++) mm[c][i] = 32'h0;
      else if (we && writable(c, waddr)) mm[c][waddr] = mrg(mm[c][waddr]);
    #1;
  endtask
  initial begin
    for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) mm[c][i] = 32'h0;
    @(posedge clk); #1;
    reset = 1; set(0, 0, 0, 0, 5, 5); tick(); reset = 0;
    set(0, 0, 0, 0, 5, 9);
    chk("rst_a0", a0, 32'h0); chk("rst_a1", a1, 32'h0);
    set(1, 5, 4'hf, 32'hDEADBEEF, 5, 5); tick();
    set(0, 0, 0, 0, 5, 5);
    chk("wr5_a0", a0, 32'hDEADBEEF); chk("wr5_b1", b1, 32'hDEADBEEF);
    reset = 1; tick(); reset = 0;
    set(0, 0, 0, 0, 5, 5);
    chk("clr5_a0", a0, 32'h0); chk("clr5_a1", a1, 32'h0);
    reset = 1; set(1, 5, 4'hf, 32'hFFFFFFFF, 5, 5);
    chk("rstbyp_a0", a0, 32'h0);
    tick(); reset = 0;
    set(0, 0, 0, 0, 5, 5);
    chk("rstwin_a0", a0, 32'h0); chk("rstwin_a1", a1, 32'h0);
    set(1, 7, 4'hf, 32'h11223344, 7, 7); tick();
    set(1, 7, 4'b0101, 32'hAABBCCDD, 7, 7);
    chk("strb_byp_a0", a0, 32'h11BB33DD); chk("strb_old_a1", a1, 32'h11223344);
    tick(); set(0, 0, 0, 0, 7, 7);
    chk("strb_b0", b0, 32'h11BB33DD); chk("strb_b1", b1, 32'h11BB33DD);
    set(1, 7, 4'h0, 32'hFFFFFFFF, 7, 7);
    chk("strb0_byp_a0", a0, 32'h11BB33DD);
    tick(); set(0, 0, 0, 0, 7, 7);
    chk("strb0_a0", a0, 32'h11BB33DD); chk("strb0_a1", a1, 32'h11BB33DD);
    set(1, 0, 4'hf, 32'hFFFFFFFF, 0, 0);
    chk("zr_same_a0", a0, 32'h0); chk("zr_same_a1", a1, 32'h0);
    tick(); set(0, 0, 0, 0, 0, 0);
    chk("zr_a0", a0, 32'h0); chk("nzr_a1", a1, 32'hFFFFFFFF);
    set(1, 3, 4'hf, 32'h12345678, 3, 3);
    chk("byp_a0", a0, 32'h12345678); chk("byp_b0", b0, 32'h12345678);
    chk("nbyp_a1", a1, 32'h0); chk("nbyp_b1", b1, 32'h0);
    tick(); set(0, 0, 0, 0, 3, 3);
    chk("nbyp_next_a1", a1, 32'h12345678); chk("nbyp_next_b1", b1, 32'h12345678);
    set(1, 30, 4'hf, 32'hFFFFFFFF, 30, 7);
    chk("oor_same_a1", a1, 32'h0); chk("r30_byp_a0", a0, 32'hFFFFFFFF);
    tick(); set(0, 0, 0, 0, 30, 7);
    chk("oor_a1", a1, 32'h0); chk("oor_r7_b1", b1, 32'h11BB33DD); chk("r30_a0", a0, 32'hFFFFFFFF);
    set(0, 0, 0, 0, 6, 14);
    chk("oor_r6_a1", a1, 32'h0); chk("oor_r14_b1", b1, 32'h0);
    set(1, 23, 4'hf, 32'hCAFEF00D, 23, 24); tick();
    set(0, 0, 0, 0, 23, 24);
    chk("r23_a0", a0, 32'hCAFEF00D); chk("r23_a1", a1, 32'hCAFEF00D);
    chk("r24_b0", b0, 32'h0); chk("r24_b1", b1, 32'h0);
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      reset = $urandom_range(99) < 2;
      set($urandom_range(3) != 0, wa, 4'($urandom), $urandom,
          $urandom_range(3) == 0 ? wa : 5'($urandom), $urandom_range(3) == 0 ? wa : 5'($urandom));
      chk("rnd_a0", a0, mrd(0, ra)); chk("rnd_b0", b0, mrd(0, rb));
      chk("rnd_a1", a1, mrd(1, ra)); chk("rnd_b1", b1, mrd(1, rb));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
